build_info_axil: RTL and testbench
==================================

# build_info_axil

Consumes the 64-bit build version value and the USR_ACCESS configuration word, qualifies the USR_ACCESS data once its valid flag is stable, and presents everything as a read-mostly AXI4-Lite register bank for the PS. It sits directly downstream of the BD version/USR_ACCESS wrapper and upstream of the PS AXI interconnect.

## Interface
- `STABLE_CYCLES`, 8: consecutive cycles of synced datavalid high with unchanged data required to capture. Range 1..255.
- `TIMEOUT_CYCLES`, 1_000_000: cycles after reset without a capture before the timeout is flagged. Range ≥ `STABLE_CYCLES`+4.
- `MAGIC`, 32'h4255_494C: constant returned at offset 0x14.

Ports:
- `clk`  in  1  AXI and logic clock.
- `rstn`  in  1  asynchronous active-low reset; deassertion is synchronous to `clk` externally.
- `version_i`  in  64  static build version; sampled directly, no synchronizer.
- `usr_datavalid_i`  in  1  USR_ACCESS DATAVALID; asynchronous to `clk`.
- `usr_data_i`  in  32  USR_ACCESS DATA; asynchronous to `clk`.
- `s_axil_awaddr`  in  5; `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata`  in  32; `s_axil_wstrb` in 4; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp`  out  2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr`  in  5; `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata`  out  32; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `usr_ready_o`  out  1  high once USR_ACCESS data is captured.

## Operation
- Register map (word-aligned, addr[1:0] ignored): 0x00 version[31:0] RO; 0x04 version[63:32] RO; 0x08 captured USR_ACCESS RO; 0x0C status RO (bit0 captured, bit1 timeout, rest 0); 0x10 scratch RW; 0x14 `MAGIC` RO. Offsets 0x18–0x1C are unmapped.
- Synchronization: `usr_datavalid_i` passes through a 2-FF synchronizer. `usr_data_i` is registered every cycle into `data_q`, with the previous sample kept in `data_qq`.
- Capture FSM:
  - RESET → WAIT on the first cycle after reset.
  - WAIT: the stability counter increments while synced valid=1 and `data_q`==`data_qq`. The counter clears otherwise.
  - WAIT → CAPTURED when the counter reaches `STABLE_CYCLES`. On that transition, `data_q` loads the capture register and status bit0 sets.
  - WAIT → TIMEOUT when the timeout counter reaches `TIMEOUT_CYCLES`. Status bit1 sets and the capture register stays 0.
  - TIMEOUT keeps watching. A later stable window moves the FSM to CAPTURED, which sets bit0 and clears bit1.
  - CAPTURED is terminal until reset.
  - If capture and timeout qualify in the same cycle, capture wins: bit0=1 and bit1=0.
- Timeout counter: saturating, and it stops counting in CAPTURED.
- Reads:
  - Single outstanding transaction.
  - `arready`=1 while `rvalid`=0.
  - On the AR handshake, rdata and rresp are registered and `rvalid` rises the next cycle. Both hold stable until `rready`.
  - Unmapped offset: rdata=0, rresp=2'b10 (SLVERR). Otherwise rresp=OKAY.
- Writes:
  - `awready` and `wready` assert together, for one cycle, only when `awvalid`, `wvalid` and !`bvalid` are all high.
  - `bvalid` rises the next cycle and holds until `bready`.
  - Scratch is updated per `wstrb` byte lane. Writes to RO offsets are ignored with bresp=OKAY. Writes to unmapped offsets return bresp=SLVERR.
- A read and a write may complete in the same cycle independently. A scratch read issued in the same cycle as a scratch write returns the old value.

## Timing
- Reset values:
  - All AXI valid/ready outputs are 0. `arready` rises 1 cycle after reset release.
  - rdata=0, resp=0, scratch=0, capture register=0, status=0, `usr_ready_o`=0, counters=0, FSM=RESET.
- Read latency: AR handshake at cycle N → `rvalid` at N+1. Back-to-back reads achieve one transfer per 2 cycles with `rready` held high.
- Write latency: AW/W handshake at N → `bvalid` at N+1.
- Capture latency from stable valid: 2 sync cycles + `STABLE_CYCLES` + 1 register cycle. `usr_ready_o` is the registered status bit0.
- Mid-operation reset: all state returns to reset values immediately and any pending `rvalid`/`bvalid` is dropped.
- `version_i` is read live. It is assumed static only in the sense that the upstream drives it from constants.

## Test plan
- Reset then read 0x00/0x04 with `version_i`=64'h0123_4567_89AB_CDEF → 0x89AB_CDEF, then 0x0123_4567, rresp=0, `rvalid` 1 cycle after AR.
- Raise valid with data=32'h5A5A_1234 held steady, `STABLE_CYCLES`=8 → `usr_ready_o` high 11 cycles later; 0x08 reads 0x5A5A_1234 and 0x0C reads 0x1.
- Toggle data every 5 cycles with `STABLE_CYCLES`=8 → no capture. Set `TIMEOUT_CYCLES`=100 → 0x0C reads 0x2 after 100 cycles; a later steady window → 0x0C reads 0x1.
- Write 0x10 with wdata=0xDEAD_BEEF and wstrb=4'b0101, then read → 0x00AD_00EF; write to 0x00 → bresp=0 and value unchanged.
- Read 0x18 → rdata=0, rresp=2'b10; write 0x1C → bresp=2'b10; read 0x14 → `MAGIC`.
- Hold `rready`=0 for 5 cycles after AR → rdata stable and `arready` low; assert `rstn`=0 mid-transfer → `rvalid`=0 and status=0 immediately.

Source files
------------

// File: rtl/build_info_axil.sv
// build_info_axil: build version / USR_ACCESS register bank on an AXI4-Lite slave.
// USR_ACCESS data is accepted only after DATAVALID has been high with unchanging
// data for STABLE_CYCLES consecutive cycles; otherwise a timeout is flagged.
module build_info_axil #(
   parameter int unsigned STABLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [31:0] MAGIC          = 32'h4255_494C
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] version_i,
   input  logic        usr_datavalid_i,
   input  logic [31:0] usr_data_i,
   input  logic [4:0]  s_axil_awaddr,
   input  logic        s_axil_awvalid,
   output logic        s_axil_awready,
   input  logic [31:0] s_axil_wdata,
   input  logic [3:0]  s_axil_wstrb,
   input  logic        s_axil_wvalid,
   output logic        s_axil_wready,
   output logic [1:0]  s_axil_bresp,
   output logic        s_axil_bvalid,
   input  logic        s_axil_bready,
   input  logic [4:0]  s_axil_araddr,
   input  logic        s_axil_arvalid,
   output logic        s_axil_arready,
   output logic [31:0] s_axil_rdata,
   output logic [1:0]  s_axil_rresp,
   output logic        s_axil_rvalid,
   input  logic        s_axil_rready,
   output logic        usr_ready_o
);

   localparam int          TW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {S_RESET, S_WAIT, S_TIMEOUT, S_CAPTURED} state_t;

   state_t          state, state_next;
   logic            valid_meta, valid_sync;
   logic [31:0]     data_q, data_qq;
   logic [7:0]      stab_cnt, stab_cnt_next;
   logic [TW-1:0]   tmo_cnt, tmo_cnt_next;
   logic [31:0]     cap_data, cap_data_next;
   logic            st_cap, st_cap_next;
   logic            st_tmo, st_tmo_next;
   logic            stable;
   logic [31:0]     scratch;
   logic [31:0]     rd_data;
   logic [1:0]      rd_resp;
   logic            wr_go, wr_hs;
   logic [3:0]      lane_we;
   logic            unused_addr_bits;

   // Byte offsets inside a word carry no meaning for this register bank.
   assign unused_addr_bits = ^{s_axil_araddr[1:0], s_axil_awaddr[1:0]};

   // DATAVALID synchronizer plus a two-deep history of the raw data word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_meta <= 1'b0;
         valid_sync <= 1'b0;
         data_q     <= '0;
         data_qq    <= '0;
      end else begin
         valid_meta <= usr_datavalid_i;
         valid_sync <= valid_meta;
         data_q     <= usr_data_i;
         data_qq    <= data_q;
      end
   end

   assign stable = valid_sync && (data_q == data_qq);

   // Capture FSM next-state: stability window, saturating timeout, capture beats timeout.
   always_comb begin
      state_next    = state;
      stab_cnt_next = '0;
      tmo_cnt_next  = tmo_cnt;
      cap_data_next = cap_data;
      st_cap_next   = st_cap;
      st_tmo_next   = st_tmo;
      if (state != S_CAPTURED && tmo_cnt != TIMEOUT_MAX)
         tmo_cnt_next = tmo_cnt + TW'(1);
      case (state)
         S_RESET: state_next = S_WAIT;
         S_WAIT, S_TIMEOUT: begin
            if (stable)
               stab_cnt_next = stab_cnt + 8'd1;
            if (stable && stab_cnt_next == STABLE_MAX) begin
               state_next    = S_CAPTURED;
               stab_cnt_next = '0;
               cap_data_next = data_q;
               st_cap_next   = 1'b1;
               st_tmo_next   = 1'b0;
            end else if (state == S_WAIT && tmo_cnt_next == TIMEOUT_MAX) begin
               state_next  = S_TIMEOUT;
               st_tmo_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Capture FSM state and status registers; usr_ready_o trails status bit0 by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_RESET;
         stab_cnt    <= '0;
         tmo_cnt     <= '0;
         cap_data    <= '0;
         st_cap      <= 1'b0;
         st_tmo      <= 1'b0;
         usr_ready_o <= 1'b0;
      end else begin
         state       <= state_next;
         stab_cnt    <= stab_cnt_next;
         tmo_cnt     <= tmo_cnt_next;
         cap_data    <= cap_data_next;
         st_cap      <= st_cap_next;
         st_tmo      <= st_tmo_next;
         usr_ready_o <= st_cap;
      end
   end

   // Read address decode; offsets 0x18/0x1C answer SLVERR with zero data.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (s_axil_araddr[4:2])
         3'd0:    rd_data = version_i[31:0];
         3'd1:    rd_data = version_i[63:32];
         3'd2:    rd_data = cap_data;
         3'd3:    rd_data = {30'd0, st_tmo, st_cap};
         3'd4:    rd_data = scratch;
         3'd5:    rd_data = MAGIC;
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   // Read channel: one outstanding read, arready mirrors !rvalid after reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_axil_arready <= 1'b0;
         s_axil_rvalid  <= 1'b0;
         s_axil_rdata   <= '0;
         s_axil_rresp   <= RESP_OKAY;
      end else if (s_axil_arvalid && s_axil_arready) begin
         s_axil_arready <= 1'b0;
         s_axil_rvalid  <= 1'b1;
         s_axil_rdata   <= rd_data;
         s_axil_rresp   <= rd_resp;
      end else if (s_axil_rvalid && s_axil_rready) begin
         s_axil_rvalid  <= 1'b0;
         s_axil_arready <= 1'b1;
      end else if (!s_axil_rvalid) begin
         s_axil_arready <= 1'b1;
      end
   end

   // AW and W are accepted together as a one-cycle ready pulse.
   assign wr_go = s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
   assign wr_hs = s_axil_awready && s_axil_awvalid && s_axil_wvalid;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = wr_hs && (s_axil_awaddr[4:2] == 3'd4) && s_axil_wstrb[gi];
   end

   // Write channel and byte-lane scratch register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_axil_awready <= 1'b0;
         s_axil_wready  <= 1'b0;
         s_axil_bvalid  <= 1'b0;
         s_axil_bresp   <= RESP_OKAY;
         scratch        <= '0;
      end else begin
         s_axil_awready <= wr_go;
         s_axil_wready  <= wr_go;
         if (wr_hs) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= (s_axil_awaddr[4:3] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axil_bvalid && s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
         end
         for (int b = 0; b < 4; b++)
            if (lane_we[b])
               scratch[8*b +: 8] <= s_axil_wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_build_info_axil.sv
// Self-checking bench for build_info_axil: directed plan steps plus randomized
// register traffic checked against a register-map model.
module tb_build_info_axil;

   localparam int          STABLE = 8;
   localparam int          TMO    = 100;
   localparam logic [31:0] MAGIC_V = 32'h4255_494C;
   localparam int          LAT    = 2 + STABLE + 1;

   logic        clk = 1'b0;
   logic        rstn;
   logic [63:0] version_i;
   logic        usr_datavalid_i;
   logic [31:0] usr_data_i;
   logic [4:0]  s_axil_awaddr;
   logic        s_axil_awvalid, s_axil_awready;
   logic [31:0] s_axil_wdata;
   logic [3:0]  s_axil_wstrb;
   logic        s_axil_wvalid, s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid, s_axil_bready;
   logic [4:0]  s_axil_araddr;
   logic        s_axil_arvalid, s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid, s_axil_rready;
   logic        usr_ready_o;

   build_info_axil #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TMO),
      .MAGIC         (MAGIC_V)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .version_i      (version_i),
      .usr_datavalid_i(usr_datavalid_i),
      .usr_data_i     (usr_data_i),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .usr_ready_o    (usr_ready_o)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int errs = 0;
   int cyc  = 0;
   int tcyc = 0;
   bit toggle_en = 1'b0;

   // Reference model of the visible register contents.
   logic [63:0] m_ver;
   logic [31:0] m_cap;
   logic [1:0]  m_status;
   logic [31:0] m_scratch;

   function automatic logic [31:0] exp_reg(input int word);
      case (word)
         0: return m_ver[31:0];
         1: return m_ver[63:32];
         2: return m_cap;
         3: return {30'd0, m_status};
         4: return m_scratch;
         5: return MAGIC_V;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [1:0] exp_resp(input int word);
      return (word >= 6) ? 2'b10 : 2'b00;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; data toggles every 5 cycles while toggling is enabled.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      tcyc++;
      if (toggle_en && (tcyc % 5 == 0))
         usr_data_i = usr_data_i + 32'd1 + 32'($urandom_range(0, 1000));
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit hs = 1'b0;
      int n  = 0;
      s_axil_araddr  = addr;
      s_axil_arvalid = 1'b1;
      while (!hs && n < 20) begin
         hs = s_axil_arready;
         tick();
         n++;
      end
      s_axil_arvalid = 1'b0;
      check("ar_handshake", {31'd0, hs}, 32'd1);
      check("rvalid_latency", {31'd0, s_axil_rvalid}, 32'd1);
      data = s_axil_rdata;
      resp = s_axil_rresp;
      s_axil_rready = 1'b1;
      tick();
      s_axil_rready = 1'b0;
      $display("RD addr=%02h data=%08h resp=%0d", addr, data, resp);
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit hs = 1'b0;
      int n  = 0;
      s_axil_awaddr  = addr;
      s_axil_wdata   = data;
      s_axil_wstrb   = strb;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      while (!hs && n < 20) begin
         hs = s_axil_awready && s_axil_wready;
         tick();
         n++;
      end
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      check("aw_handshake", {31'd0, hs}, 32'd1);
      check("bvalid_latency", {31'd0, s_axil_bvalid}, 32'd1);
      resp = s_axil_bresp;
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;
      $display("WR addr=%02h data=%08h strb=%b resp=%0d", addr, data, strb, resp);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr,
                         input logic [31:0] exp_d, input logic [1:0] exp_r);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(addr, d, r);
      check(tag, d, exp_d);
      check({tag, "_resp"}, {30'd0, r}, {30'd0, exp_r});
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] res = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
      return res;
   endfunction

   initial begin
      logic [1:0]  br;
      logic [31:0] d;
      logic [1:0]  r;
      int          word;

      rstn = 1'b0;
      m_ver = 64'h0123_4567_89AB_CDEF;
      version_i = m_ver;
      usr_datavalid_i = 1'b0;
      usr_data_i = 32'h5A5A_1234;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
      s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
      m_cap = '0; m_status = '0; m_scratch = '0;

      // Reset state.
      repeat (3) tick();
      check("rst_arready", {31'd0, s_axil_arready}, 32'd0);
      check("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
      check("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
      check("rst_awready", {31'd0, s_axil_awready}, 32'd0);
      check("rst_usr_ready", {31'd0, usr_ready_o}, 32'd0);
      rstn = 1'b1;
      cyc = 0;
      check("arready_at_release", {31'd0, s_axil_arready}, 32'd0);
      tick();
      check("arready_after_release", {31'd0, s_axil_arready}, 32'd1);

      // Version and initial status.
      rd_chk("ver_lo", 5'h00, 32'h89AB_CDEF, 2'b00);
      rd_chk("ver_hi", 5'h04, 32'h0123_4567, 2'b00);
      rd_chk("status_init", 5'h0C, 32'h0, 2'b00);
      rd_chk("cap_init", 5'h08, 32'h0, 2'b00);

      // Steady capture: usr_ready_o rises LAT cycles after valid.
      usr_datavalid_i = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k == LAT - 1) check("usr_ready_early", {31'd0, usr_ready_o}, 32'd0);
         if (k == LAT)     check("usr_ready_on_time", {31'd0, usr_ready_o}, 32'd1);
      end
      m_cap = 32'h5A5A_1234;
      m_status = 2'b01;
      rd_chk("cap_val", 5'h08, m_cap, 2'b00);
      rd_chk("status_cap", 5'h0C, 32'h1, 2'b00);
      usr_data_i = 32'h1111_2222;
      repeat (20) tick();
      rd_chk("cap_terminal", 5'h08, m_cap, 2'b00);

      // Scratch byte lanes, RO write, unmapped, magic.
      axi_write(5'h10, 32'hDEAD_BEEF, 4'b0101, br);
      check("wr_scratch_bresp", {30'd0, br}, 32'd0);
      m_scratch = merge(m_scratch, 32'hDEAD_BEEF, 4'b0101);
      rd_chk("scratch_strb", 5'h10, 32'h00AD_00EF, 2'b00);
      axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, br);
      check("wr_ro_bresp", {30'd0, br}, 32'd0);
      rd_chk("ro_unchanged", 5'h00, 32'h89AB_CDEF, 2'b00);
      rd_chk("unmapped_rd", 5'h18, 32'h0, 2'b10);
      axi_write(5'h1C, 32'h1234_5678, 4'hF, br);
      check("unmapped_bresp", {30'd0, br}, 32'd2);
      rd_chk("magic", 5'h14, MAGIC_V, 2'b00);

      // Randomized register traffic against the model.
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) begin
            m_ver = {$urandom, $urandom};
            version_i = m_ver;
         end
         word = int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            r = 2'($urandom_range(0, 3));
            axi_write({3'(word), r}, d, 4'($urandom_range(0, 15)), br);
            check("rand_bresp", {30'd0, br}, {30'd0, exp_resp(word)});
            if (word == 4) m_scratch = merge(m_scratch, d, s_axil_wstrb);
         end else begin
            r = 2'($urandom_range(0, 3));
            rd_chk("rand_rd", {3'(word), r}, exp_reg(word), exp_resp(word));
         end
      end

      // rready held low: response holds; then reset mid-transfer.
      axi_write(5'h10, 32'hCAFE_F00D, 4'hF, br);
      m_scratch = 32'hCAFE_F00D;
      s_axil_araddr = 5'h10;
      s_axil_arvalid = 1'b1;
      begin
         bit hs = 1'b0;
         int n = 0;
         while (!hs && n < 20) begin
            hs = s_axil_arready;
            tick();
            n++;
         end
         check("hold_ar_handshake", {31'd0, hs}, 32'd1);
      end
      s_axil_arvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("hold_rvalid", {31'd0, s_axil_rvalid}, 32'd1);
         check("hold_rdata", s_axil_rdata, m_scratch);
         check("hold_arready", {31'd0, s_axil_arready}, 32'd0);
         tick();
      end
      usr_datavalid_i = 1'b0;
      rstn = 1'b0;
      #1;
      check("midrst_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
      check("midrst_usr_ready", {31'd0, usr_ready_o}, 32'd0);
      check("midrst_arready", {31'd0, s_axil_arready}, 32'd0);
      $display("RST mid-transfer asserted");
      repeat (2) tick();
      rstn = 1'b1;
      cyc = 0;
      m_status = 2'b00; m_cap = '0; m_scratch = '0;
      rd_chk("status_after_rst", 5'h0C, 32'h0, 2'b00);
      rd_chk("scratch_after_rst", 5'h10, 32'h0, 2'b00);

      // Toggling data never qualifies; timeout flags, then a steady window captures.
      toggle_en = 1'b1;
      usr_datavalid_i = 1'b1;
      while (cyc < 60) tick();
      rd_chk("status_pre_tmo", 5'h0C, 32'h0, 2'b00);
      while (cyc < TMO + 10) tick();
      m_status = 2'b10;
      rd_chk("status_tmo", 5'h0C, 32'h2, 2'b00);
      rd_chk("cap_tmo", 5'h08, 32'h0, 2'b00);
      check("usr_ready_tmo", {31'd0, usr_ready_o}, 32'd0);
      toggle_en = 1'b0;
      repeat (LAT + 4) tick();
      m_status = 2'b01;
      m_cap = usr_data_i;
      check("usr_ready_late", {31'd0, usr_ready_o}, 32'd1);
      rd_chk("status_late_cap", 5'h0C, 32'h1, 2'b00);
      rd_chk("cap_late", 5'h08, m_cap, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
